// File: rtl/keccak_pkg.sv
// ---------------------------------------------------------------------------
// keccak_pkg
// Shared types and constants for the Keccak-f[1600] round controller.
//   ctrl_state_t       controller FSM states (IDLE, ROUND, DONE)
//   KECCAK_MAX_ROUNDS  rounds in a full Keccak-f[1600] permutation
//   RC_IDX_W           width of the one-hot round index (always 24)
//   ROUND_IDX_W        width of the binary round number
// ---------------------------------------------------------------------------
package keccak_pkg;

    localparam int KECCAK_MAX_ROUNDS = 24;
    localparam int RC_IDX_W          = 24;
    localparam int ROUND_IDX_W       = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } ctrl_state_t;

endpackage : keccak_pkg

// File: rtl/keccak_round_ctrl_onehot_shift.sv
// ---------------------------------------------------------------------------
// round_onehot_shift
// One-hot round index shifter with a binary round counter kept in lockstep.
// Priority of controls: clear > seed > shift.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   clear        zero both the one-hot index and the counter
//   seed         load one-hot 24'h000001 and counter 0
//   shift        advance one round (one-hot << 1, counter + 1)
//   round_i      one-hot round index
//   round_idx    binary round number
//   last         high when round_idx == NUM_ROUNDS-1
// ---------------------------------------------------------------------------
module round_onehot_shift
    import keccak_pkg::*;
#(
    parameter int NUM_ROUNDS = KECCAK_MAX_ROUNDS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   seed,
    input  logic                   shift,
    output logic [RC_IDX_W-1:0]    round_i,
    output logic [ROUND_IDX_W-1:0] round_idx,
    output logic                   last
);

    localparam logic [ROUND_IDX_W-1:0] LAST_IDX = ROUND_IDX_W'(NUM_ROUNDS - 1);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples its inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            round_i   <= '0;
            round_idx <= '0;
        end else if (clear) begin
            round_i   <= '0;
            round_idx <= '0;
        end else if (seed) begin
            round_i   <= RC_IDX_W'(1);
            round_idx <= '0;
        end else if (shift) begin
            round_i   <= {round_i[RC_IDX_W-2:0], 1'b0};
            round_idx <= round_idx + 1'b1;
        end
    end

    // The controller clears instead of shifting when last is high, so the
    // one-hot bit never moves past NUM_ROUNDS-1.
    assign last = (round_idx == LAST_IDX);

endmodule : round_onehot_shift

// File: rtl/keccak_round_ctrl.sv
// ---------------------------------------------------------------------------
// keccak_round_ctrl
// Sequences the Keccak-f[1600] round datapath for one absorbed block:
// accept handshake -> load strobe -> NUM_ROUNDS round enables with a one-hot
// round index -> result held on a valid/ready handshake.
// Optional feature macro: KECCAK_CTRL_ABORT_EN adds the abort input, which
// returns the controller to IDLE from ROUND or DONE without a result.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   in_valid     block available to absorb
//   in_ready     controller can accept a block (IDLE only)
//   load_en      1-cycle strobe, datapath loads/XORs the block into state
//   round_en     datapath registers one round result this cycle
//   round_i      one-hot round index (0 outside ROUND)
//   round_idx    binary round number (0 outside ROUND)
//   busy         high in ROUND or DONE
//   out_valid    permuted state valid
//   abort        (KECCAK_CTRL_ABORT_EN only) abandon current permutation
//   out_ready    consumer accepts the result
// ---------------------------------------------------------------------------
module keccak_round_ctrl
    import keccak_pkg::*;
#(
    parameter int NUM_ROUNDS = KECCAK_MAX_ROUNDS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   load_en,
    output logic                   round_en,
    output logic [RC_IDX_W-1:0]    round_i,
    output logic [ROUND_IDX_W-1:0] round_idx,
    output logic                   busy,
    output logic                   out_valid,
`ifdef KECCAK_CTRL_ABORT_EN
    input  logic                   abort,
`endif
    input  logic                   out_ready
);

    ctrl_state_t state_q, state_d;
    logic        sh_clear, sh_seed, sh_shift, sh_last;

    round_onehot_shift #(
        .NUM_ROUNDS (NUM_ROUNDS)
    ) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (sh_clear),
        .seed      (sh_seed),
        .shift     (sh_shift),
        .round_i   (round_i),
        .round_idx (round_idx),
        .last      (sh_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        load_en   = 1'b0;
        round_en  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        sh_clear  = 1'b0;
        sh_seed   = 1'b0;
        sh_shift  = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_en = 1'b1;
                    sh_seed = 1'b1;
                    state_d = ROUND;
                end
            end

            ROUND: begin
                busy     = 1'b1;
                round_en = 1'b1;
`ifdef KECCAK_CTRL_ABORT_EN
                if (abort) begin
                    sh_clear = 1'b1;
                    state_d  = IDLE;
                end else
`endif
                if (sh_last) begin
                    sh_clear = 1'b1;
                    state_d  = DONE;
                end else begin
                    sh_shift = 1'b1;
                end
            end

            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
`ifdef KECCAK_CTRL_ABORT_EN
                // An abort suppresses the result so no handshake can complete.
                if (abort) begin
                    out_valid = 1'b0;
                    state_d   = IDLE;
                end else
`endif
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule : keccak_round_ctrl
